cnt_seq_checker: RTL and testbench
==================================

# cnt_seq_checker

Receive-side checker for the free-running counter pair driven by the counter generator (`a` increments by 1 per clock, `b` carries the previous `a`). It consumes the `a`/`b` sample stream and checks two things: `a` advances by exactly 1 modulo 2^W, and `b` equals the prior `a`. It counts samples and mismatches, captures the first failure, and re-locks after each error. It sits in the same clock domain as the generator and serves as the in-design monitor for ordering and race bugs.

## Interface
- `W`, default 4: width of the counter values.
- `SCNT_W`, default 16: width of the sample counter (wraps).
- `ECNT_W`, default 8: width of the error counter (saturates).
- `clk`  in  1: clock; all logic is on the rising edge.
- `rstn`  in  1: reset, synchronous, active-high; while 1 at a rising edge, all state returns to reset values.
- `sync_clr`  in  1: restart lock acquisition. Drops to IDLE; counters and capture are kept.
- `in_vld`  in  1: `in_a`/`in_b` hold a valid sample this cycle.
- `in_a`  in  W: counter value `a`.
- `in_b`  in  W: delayed value `b`.
- `locked`  out  1: the checker has a reference value and is checking.
- `err_pulse`  out  1: one-cycle flag for a mismatch on the previous sample.
- `err_sticky`  out  1: set on the first mismatch; held until reset.
- `err_cnt`  out  ECNT_W: mismatch count, saturating at all-ones.
- `sample_cnt`  out  SCNT_W: count of valid samples accepted, wraps.
- `first_exp_a`, `first_got_a`  out  W: expected and received `a` at the first mismatch.
- `first_exp_b`, `first_got_b`  out  W: expected and received `b` at the first mismatch.

## Operation
- Reset values: state IDLE, `locked`=0, `err_pulse`=0, `err_sticky`=0, `err_cnt`=0, `sample_cnt`=0, all `first_*`=0, `prev_a`=0.
- States: IDLE, CHECK.
- IDLE, on `in_vld`=1:
  - `prev_a` <= `in_a`.
  - Go to CHECK.
  - `sample_cnt`++.
  - No comparison is made; the seed sample is never an error.
- CHECK, on `in_vld`=1:
  - `exp_a` = `prev_a`+1, truncated to W bits (wraps 2^W-1 -> 0).
  - `exp_b` = `prev_a`.
  - Mismatch = (`in_a`!=`exp_a`) OR (`in_b`!=`exp_b`).
  - On mismatch:
    - Assert `err_pulse`.
    - Increment `err_cnt` unless it is all-ones.
    - If `err_sticky`=0: load all `first_*`, then set `err_sticky`.
    - Stay in CHECK.
  - In all cases: `prev_a` <= `in_a` (re-seed from the received value, so one glitch costs one error, not a burst). `sample_cnt`++.
- `in_vld`=0: no state change, no comparison. `prev_a` holds, so gaps are transparent.
- `sync_clr`=1: next state is IDLE and `locked`=0. Same-cycle `in_vld` sample is discarded, with no count and no compare. `err_*`, `first_*` and `sample_cnt` keep their values.
- Reset mid-stream: `rstn` overrides `sync_clr` and `in_vld`. The first valid sample after `rstn` drops is a seed.
- A generator reset (`a`=0,`b`=0 mid-stream) appears as a mismatch unless the environment pulses `sync_clr`. This is intended.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Sample valid at edge N -> `err_pulse`, `err_cnt`, `sample_cnt`, `first_*` update at edge N, visible in cycle N+1. Latency is 1 cycle.
- `locked` rises the cycle after the seed sample and falls the cycle after `sync_clr` or `rstn`.
- Back-to-back errors give back-to-back `err_pulse` cycles. `err_pulse` is never stretched.
- `sample_cnt` wraps from 2^SCNT_W-1 to 0 silently. `err_cnt` holds at 2^ECNT_W-1.

## Structure
- Package `cnt_seq_pkg`: state enum `chk_state_e` {IDLE, CHECK}, and default width constants `CNT_W_DEF`=4, `SCNT_W_DEF`=16, `ECNT_W_DEF`=8.
- Sub-module `sat_cnt` (parameter width; inputs inc, clr; output value; saturates at all-ones; sync active-high clear) implements `err_cnt`.
- Top-level contents: FSM, `prev_a` register, comparators, first-error capture.

## Test plan
- Clean run: reset, then 40 generator cycles with `a` 0..15 wrapping and `b`=previous `a` -> `locked`=1 from cycle 2, `err_cnt`=0, `err_sticky`=0, `sample_cnt`=40.
- Wrap boundary: seed `a`=14, then `a`=15,`b`=14, then `a`=0,`b`=15 -> no `err_pulse`.
- Single glitch: in a clean stream with `prev_a`=5, drive `a`=9,`b`=5 -> `err_pulse`=1 for exactly one cycle, `first_exp_a`=6, `first_got_a`=9. The next sample `a`=10,`b`=9 is clean and `err_cnt` stays 1.
- Race signature: drive `b`=`a` (same-cycle value, e.g. `a`=3,`b`=3 after `prev_a`=2) -> mismatch on `b`, `first_exp_b`=2, `first_got_b`=3, and `err_cnt` increments on every such sample.
- Saturation: with `ECNT_W`=2, inject 6 consecutive mismatches -> `err_cnt` sequence 1,2,3,3,3,3, and `first_*` unchanged after the first.
- `sync_clr` and reset: `sync_clr` together with `in_vld` -> the sample is not counted and `locked`=0 next cycle, and the next sample reseeds with no error. `rstn` pulse mid-stream -> all outputs return to 0 the following cycle.

Source files
------------

// File: rtl/cnt_seq_pkg.sv
// Shared types and default widths for the counter sequence checker.
package cnt_seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } chk_state_e;

  localparam int CNT_W_DEF  = 4;
  localparam int SCNT_W_DEF = 16;
  localparam int ECNT_W_DEF = 8;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  // Count up on inc until all-ones; clear has priority.
  always_ff @(posedge clk) begin
    if (clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + ONE;
    end
  end

endmodule

// File: rtl/cnt_seq_checker.sv
// Receive-side checker for the a/b counter pair: a must advance by one
// (mod 2^W) and b must equal the previous a. Counts samples and errors,
// captures the first failure and re-seeds from every received sample.
//
// state | meaning
// IDLE  | no reference yet; next valid sample seeds prev_a
// CHECK | reference held; every valid sample is compared
module cnt_seq_checker
  import cnt_seq_pkg::*;
#(
  parameter int W      = CNT_W_DEF,
  parameter int SCNT_W = SCNT_W_DEF,
  parameter int ECNT_W = ECNT_W_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sync_clr,
  input  logic              in_vld,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  output logic              locked,
  output logic              err_pulse,
  output logic              err_sticky,
  output logic [ECNT_W-1:0] err_cnt,
  output logic [SCNT_W-1:0] sample_cnt,
  output logic [W-1:0]      first_exp_a,
  output logic [W-1:0]      first_got_a,
  output logic [W-1:0]      first_exp_b,
  output logic [W-1:0]      first_got_b
);

  localparam logic [W-1:0]      ONE_W = W'(1);
  localparam logic [SCNT_W-1:0] ONE_S = SCNT_W'(1);

  chk_state_e   state;
  chk_state_e   state_nxt;
  logic [W-1:0] prev_a;
  logic [W-1:0] exp_a;
  logic [W-1:0] exp_b;
  logic         take;
  logic         cmp;
  logic         mismatch;

  // A sample arriving together with sync_clr is dropped entirely.
  assign take     = in_vld && !sync_clr;
  assign cmp      = take && (state == CHECK);
  assign exp_a    = prev_a + ONE_W;
  assign exp_b    = prev_a;
  assign mismatch = cmp && ((in_a != exp_a) || (in_b != exp_b));

  // locked is a decode of the state register, so it stays registered.
  assign locked = (state == CHECK);

  // State register.
  always_ff @(posedge clk) begin
    if (rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: seed on the first valid sample, drop back on sync_clr.
  always_comb begin
    state_nxt = state;
    if (sync_clr) begin
      state_nxt = IDLE;
    end else if (in_vld && (state == IDLE)) begin
      state_nxt = CHECK;
    end
  end

  // Reference, sample count, error flags and first-failure capture.
  always_ff @(posedge clk) begin
    if (rstn) begin
      prev_a      <= '0;
      sample_cnt  <= '0;
      err_pulse   <= 1'b0;
      err_sticky  <= 1'b0;
      first_exp_a <= '0;
      first_got_a <= '0;
      first_exp_b <= '0;
      first_got_b <= '0;
    end else begin
      err_pulse <= mismatch;
      if (take) begin
        // Re-seed from what was received so a single glitch costs one error.
        prev_a     <= in_a;
        sample_cnt <= sample_cnt + ONE_S;
      end
      if (mismatch && !err_sticky) begin
        first_exp_a <= exp_a;
        first_got_a <= in_a;
        first_exp_b <= exp_b;
        first_got_b <= in_b;
        err_sticky  <= 1'b1;
      end
    end
  end

  sat_cnt #(
    .WIDTH(ECNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .inc  (mismatch),
    .clr  (rstn),
    .value(err_cnt)
  );

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Bench for cnt_seq_checker: two instances (default widths and a 2-bit
// error counter) share one stimulus stream and are compared every cycle
// against a behavioural model, with literal spot checks per scenario.
module tb_cnt_seq_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, sync_clr, in_vld;
  logic [3:0] in_a, in_b;

  logic        locked1, pulse1, sticky1;
  logic [7:0]  ecnt1;
  logic [15:0] scnt1;
  logic [3:0]  fea1, fga1, feb1, fgb1;

  logic        locked2, pulse2, sticky2;
  logic [1:0]  ecnt2;
  logic [15:0] scnt2;
  logic [3:0]  fea2, fga2, feb2, fgb2;

  cnt_seq_checker dut1 (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .in_vld(in_vld),
    .in_a(in_a), .in_b(in_b), .locked(locked1), .err_pulse(pulse1),
    .err_sticky(sticky1), .err_cnt(ecnt1), .sample_cnt(scnt1),
    .first_exp_a(fea1), .first_got_a(fga1),
    .first_exp_b(feb1), .first_got_b(fgb1)
  );

  cnt_seq_checker #(.ECNT_W(2)) dut2 (
    .clk(clk), .rstn(rstn), .sync_clr(sync_clr), .in_vld(in_vld),
    .in_a(in_a), .in_b(in_b), .locked(locked2), .err_pulse(pulse2),
    .err_sticky(sticky2), .err_cnt(ecnt2), .sample_cnt(scnt2),
    .first_exp_a(fea2), .first_got_a(fga2),
    .first_exp_b(feb2), .first_got_b(fgb2)
  );

  int n_vec  = 0;
  int n_fail = 0;
  bit armed  = 1'b0;

  // Behavioural model state (plain integers).
  bit m_have, m_pulse, m_sticky;
  int m_ref, m_scnt, m_e8, m_e2;
  int m_fea, m_fga, m_feb, m_fgb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: apply the checker rules to the inputs seen at each rising edge.
  always @(posedge clk) begin : model
    int  ea, eb;
    bit  mm;
    if (rstn) begin
      m_have = 0; m_pulse = 0; m_sticky = 0; m_ref = 0; m_scnt = 0;
      m_e8 = 0; m_e2 = 0; m_fea = 0; m_fga = 0; m_feb = 0; m_fgb = 0;
    end else if (sync_clr) begin
      m_have  = 0;
      m_pulse = 0;
    end else if (in_vld) begin
      if (!m_have) begin
        m_have  = 1;
        m_pulse = 0;
      end else begin
        ea = (m_ref + 1) % 16;
        eb = m_ref;
        mm = (int'(in_a) != ea) || (int'(in_b) != eb);
        m_pulse = mm;
        if (mm) begin
          if (m_e8 < 255) m_e8++;
          if (m_e2 < 3) m_e2++;
          if (!m_sticky) begin
            m_sticky = 1;
            m_fea = ea; m_fga = int'(in_a); m_feb = eb; m_fgb = int'(in_b);
          end
        end
      end
      m_ref  = int'(in_a);
      m_scnt = (m_scnt + 1) % 65536;
    end else begin
      m_pulse = 0;
    end
  end

  // Compare both instances against the model every cycle once reset has run.
  always @(negedge clk) begin
    if (armed) begin
      chk("locked1", locked1, m_have);   chk("locked2", locked2, m_have);
      chk("pulse1", pulse1, m_pulse);    chk("pulse2", pulse2, m_pulse);
      chk("sticky1", sticky1, m_sticky); chk("sticky2", sticky2, m_sticky);
      chk("ecnt1", ecnt1, m_e8);         chk("ecnt2", ecnt2, m_e2);
      chk("scnt1", scnt1, m_scnt);       chk("scnt2", scnt2, m_scnt);
      chk("fea1", fea1, m_fea); chk("fga1", fga1, m_fga);
      chk("feb1", feb1, m_feb); chk("fgb1", fgb1, m_fgb);
      chk("fea2", fea2, m_fea); chk("fga2", fga2, m_fga);
      chk("feb2", feb2, m_feb); chk("fgb2", fgb2, m_fgb);
    end
  end

  // Drive one cycle of inputs (called just after a falling edge).
  task automatic step(input bit r, input bit c, input bit v, input int a, input int b);
    rstn = r; sync_clr = c; in_vld = v;
    in_a = a[3:0]; in_b = b[3:0];
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int g, a, b, r;
    bit rr, cc, vv;
    rstn = 1'b1; sync_clr = 1'b0; in_vld = 1'b0; in_a = '0; in_b = '0;
    @(negedge clk);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    armed = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("rst_locked", locked1, 0);
    chk("rst_scnt", scnt1, 0);
    chk("rst_ecnt", ecnt1, 0);

    // Clean generator run.
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, i % 16, (i + 15) % 16);
      if (i == 0) chk("clean_locked", locked1, 1);
    end
    chk("clean_scnt", scnt1, 40);
    chk("clean_ecnt", ecnt1, 0);
    chk("clean_sticky", sticky1, 0);

    // sync_clr with a valid sample: dropped, lock lost.
    step(0, 1, 1, 8, 7);
    chk("clr_locked", locked1, 0);
    chk("clr_scnt", scnt1, 40);

    // Wrap boundary after reseed.
    step(0, 0, 1, 14, 13);
    chk("wrap_seed_pulse", pulse1, 0);
    step(0, 0, 1, 15, 14);
    chk("wrap_15_pulse", pulse1, 0);
    step(0, 0, 1, 0, 15);
    chk("wrap_0_pulse", pulse1, 0);
    chk("wrap_ecnt", ecnt1, 0);
    chk("wrap_scnt", scnt1, 43);

    // Single glitch after prev_a = 5.
    for (int i = 1; i <= 5; i++) step(0, 0, 1, i, i - 1);
    step(0, 0, 1, 9, 5);
    chk("glitch_pulse", pulse1, 1);
    chk("glitch_fea", fea1, 6);
    chk("glitch_fga", fga1, 9);
    chk("glitch_ecnt", ecnt1, 1);
    step(0, 0, 1, 10, 9);
    chk("glitch_after_pulse", pulse1, 0);
    chk("glitch_after_ecnt", ecnt1, 1);

    // Race signature b == a from a fresh reset.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 2, 1);
    step(0, 0, 1, 3, 3);
    chk("race_feb", feb1, 2);
    chk("race_fgb", fgb1, 3);
    chk("race_ecnt1", ecnt1, 1);
    step(0, 0, 1, 4, 4);
    chk("race_ecnt2", ecnt1, 2);
    chk("race_pulse2", pulse1, 1);
    step(0, 0, 1, 5, 5);
    chk("race_ecnt3", ecnt1, 3);

    // Saturation on the 2-bit error counter.
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 15);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 1, k, k);
      chk("sat_ecnt2", ecnt2, (k < 3) ? k : 3);
      chk("sat_pulse2", pulse2, 1);
    end
    chk("sat_fea2", fea2, 1);
    chk("sat_fga2", fga2, 1);
    chk("sat_feb2", feb2, 0);
    chk("sat_fgb2", fgb2, 1);
    chk("sat_ecnt1", ecnt1, 6);

    // Reset mid-stream with a valid sample present.
    step(1, 0, 1, 7, 6);
    chk("mrst_locked", locked1, 0);
    chk("mrst_pulse", pulse1, 0);
    chk("mrst_sticky", sticky1, 0);
    chk("mrst_ecnt", ecnt1, 0);
    chk("mrst_scnt", scnt1, 0);
    chk("mrst_fea", fea1, 0);
    chk("mrst_fgb", fgb1, 0);
    step(0, 0, 1, 3, 9);
    chk("mrst_seed_pulse", pulse1, 0);
    chk("mrst_seed_locked", locked1, 1);
    chk("mrst_seed_scnt", scnt1, 1);

    // Randomized generator stream with gaps, glitches, clears and resets.
    g = 4;
    for (int n = 0; n < 600; n++) begin
      r  = int'($urandom_range(0, 199));
      rr = (r == 0);
      cc = (r >= 1 && r < 7);
      vv = ($urandom_range(0, 3) != 0);
      a  = g;
      b  = (g + 15) % 16;
      case ($urandom_range(0, 19))
        0: a = int'($urandom_range(0, 15));
        1: b = a;
        2: b = int'($urandom_range(0, 15));
        3: begin a = 0; b = 0; g = 0; end
        default: ;
      endcase
      step(rr, cc, vv, a, b);
      if (vv && !cc && !rr) g = (a + 1) % 16;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
